// File: rtl/da_bit_sequencer.sv
// da_bit_sequencer: bit-serial plane walker driving the DA LUT address and shift-accumulate control
module da_bit_sequencer #(
  parameter int DATA_WIDTH_A = 16,
  parameter int K            = 9,
  parameter int PIPE_LAT     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [K*DATA_WIDTH_A-1:0] A_in,
  output logic                      gen_done,
  output logic                      A0,
  output logic [K-2:0]              addr_array,
  output logic [7:0]                t,
  output logic                      acc_clr,
  output logic                      last_bit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);
  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, VALID} state_t;

  localparam logic [7:0] T_LAST = 8'(DATA_WIDTH_A - 1);
  localparam logic [3:0] D_LAST = 4'(PIPE_LAT - 1);

  if (DATA_WIDTH_A < 1 || DATA_WIDTH_A > 256 || K < 2 || PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_bad_params
    $error("da_bit_sequencer: illegal parameters DATA_WIDTH_A=%0d K=%0d PIPE_LAT=%0d", DATA_WIDTH_A, K, PIPE_LAT);
  end

  state_t                    state, state_n;
  logic [K*DATA_WIDTH_A-1:0] vec, vec_n;
  logic [7:0]                t_n;
  logic [3:0]                cnt, cnt_n;
  logic                      a0_n;
  logic [K-2:0]              addr_n;

  // next state, captured vector, bit index and drain counter
  always_comb begin
    state_n = state;
    vec_n   = vec;
    t_n     = t;
    cnt_n   = cnt;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        state_n = CLR;
        vec_n   = A_in;
        t_n     = '0;
      end
      CLR: begin
        state_n = RUN;
        t_n     = '0;
      end
      RUN: if (t == T_LAST) begin
        state_n = (PIPE_LAT == 0) ? VALID : DRAIN;
        cnt_n   = '0;
      end else begin
        t_n = t + 8'd1;
      end
      DRAIN: begin
        cnt_n   = cnt + 4'd1;
        state_n = (cnt == D_LAST) ? VALID : DRAIN;
      end
      VALID: state_n = out_ready ? IDLE : VALID;
      default: state_n = IDLE;
    endcase
  end

  // LUT address for the plane about to be presented: element 0's bit selects the offset-binary polarity
  always_comb begin
    a0_n   = 1'b0;
    addr_n = '0;
    if (state_n == RUN) begin
      a0_n = vec_n[int'(t_n)];
      for (int j = 1; j < K; j++)
        addr_n[j-1] = ~(vec_n[j*DATA_WIDTH_A + int'(t_n)] ^ vec_n[int'(t_n)]);
    end
  end

  // all outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      vec        <= '0;
      t          <= '0;
      cnt        <= '0;
      in_ready   <= 1'b0;
      acc_clr    <= 1'b0;
      gen_done   <= 1'b0;
      A0         <= 1'b0;
      addr_array <= '0;
      last_bit   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      t          <= t_n;
      cnt        <= cnt_n;
      in_ready   <= state_n == IDLE;
      acc_clr    <= state_n == CLR;
      gen_done   <= state_n == RUN;
      A0         <= a0_n;
      addr_array <= addr_n;
      last_bit   <= (state_n == RUN) && (t_n == T_LAST);
      out_valid  <= state_n == VALID;
      busy       <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_da_bit_sequencer.sv
// tb_da_bit_sequencer: directed scoreboard bench for da_bit_sequencer with PIPE_LAT=1 and PIPE_LAT=0 instances
module tb_da_bit_sequencer;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         iv = 1'b0;
  logic         use0 = 1'b0;
  logic         out_ready = 1'b1;
  logic [143:0] a_in = '0;

  logic ir_1, gd_1, a0_1, clr_1, lb_1, ov_1, busy_1;
  logic ir_0, gd_0, a0_0, clr_0, lb_0, ov_0, busy_0;
  logic [7:0] addr_1, t_1, addr_0, t_0;

  logic o_ir, o_gd, o_a0, o_clr, o_lb, o_ov, o_busy;
  logic [7:0] o_addr, o_t;

  int n_chk = 0;
  int n_pass = 0;
  logic [17:0] q[$];

  localparam logic [143:0] V4 = 144'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_5A5A;
  localparam logic [143:0] V5 = 144'hF00F_1357_2468_8001_7FFE_0F0F_C3C3_9999_6D2B;

  da_bit_sequencer #(.DATA_WIDTH_A(16), .K(9), .PIPE_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv & ~use0), .in_ready(ir_1), .A_in(a_in),
    .gen_done(gd_1), .A0(a0_1), .addr_array(addr_1), .t(t_1), .acc_clr(clr_1),
    .last_bit(lb_1), .out_valid(ov_1), .out_ready(out_ready), .busy(busy_1)
  );

  da_bit_sequencer #(.DATA_WIDTH_A(16), .K(9), .PIPE_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv & use0), .in_ready(ir_0), .A_in(a_in),
    .gen_done(gd_0), .A0(a0_0), .addr_array(addr_0), .t(t_0), .acc_clr(clr_0),
    .last_bit(lb_0), .out_valid(ov_0), .out_ready(out_ready), .busy(busy_0)
  );

  always #5 clk = ~clk;

  always_comb begin
    o_ir   = use0 ? ir_0   : ir_1;
    o_gd   = use0 ? gd_0   : gd_1;
    o_a0   = use0 ? a0_0   : a0_1;
    o_clr  = use0 ? clr_0  : clr_1;
    o_lb   = use0 ? lb_0   : lb_1;
    o_ov   = use0 ? ov_0   : ov_1;
    o_busy = use0 ? busy_0 : busy_1;
    o_addr = use0 ? addr_0 : addr_1;
    o_t    = use0 ? t_0    : t_1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [143:0] fill(input logic [15:0] e0, input logic [15:0] r);
    return {{8{r}}, e0};
  endfunction

  task automatic push_exp(input logic [143:0] v);
    for (int b = 0; b < 16; b++) begin
      logic [7:0] ad;
      for (int j = 1; j < 9; j++) ad[j-1] = ~(v[j*16+b] ^ v[b]);
      q.push_back({v[b], ad, 8'(b), b == 15});
    end
  endtask

  task automatic wait_hs(output int m);
    logic hs;
    m = 0;
    do begin
      hs = o_ir && iv;
      tick;
      m++;
    end while (!hs && m < 60);
    check("handshake_seen", {31'd0, hs}, 1);
  endtask

  task automatic run_beats(input int lat);
    int n;
    int beats;
    logic [17:0] exp;
    n = 1;
    beats = 0;
    check("acc_clr_pulse", {31'd0, o_clr}, 1);
    check("clr_gen_done", {31'd0, o_gd}, 0);
    check("clr_t", o_t, 0);
    check("clr_busy", {31'd0, o_busy}, 1);
    check("run_in_ready", {31'd0, o_ir}, 0);
    while (!o_ov && n < 100) begin
      tick;
      n++;
      check("acc_clr_once", {31'd0, o_clr}, 0);
      if (o_gd) begin
        exp = (q.size() != 0) ? q.pop_front() : 18'h3FFFF;
        check("beat", {o_a0, o_addr, o_t, o_lb}, exp);
        beats++;
      end else if (!o_ov) begin
        check("drain_pins", {o_a0, o_addr, o_lb}, 0);
        check("drain_t", o_t, 15);
      end
    end
    check("out_valid_latency", n, 18 + lat);
    check("beat_count", beats, 16);
    check("sb_drained", q.size(), 0);
  endtask

  initial begin
    int m;
    int k;
    int seen;
    repeat (3) tick;
    check("rst_in_ready", {31'd0, o_ir}, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_outs", {o_gd, o_a0, o_addr, o_t, o_clr, o_lb, o_ov}, 0);
    rst = 1'b1;
    tick;
    repeat (2) begin
      tick;
      check("idle_in_ready", {31'd0, o_ir}, 1);
      check("idle_busy", {31'd0, o_busy}, 0);
      check("idle_outs", {o_gd, o_a0, o_addr, o_t, o_clr, o_lb, o_ov}, 0);
    end
    a_in = fill(16'h0001, 16'h0001);
    push_exp(a_in);
    iv = 1'b1;
    wait_hs(m);
    iv = 1'b0;
    run_beats(1);
    tick;
    check("t2_ov_drop", {31'd0, o_ov}, 0);
    check("t2_back_idle", {31'd0, o_ir}, 1);
    a_in = fill(16'h8000, 16'hFFFF);
    push_exp(a_in);
    iv = 1'b1;
    wait_hs(m);
    iv = 1'b0;
    run_beats(1);
    tick;
    out_ready = 1'b0;
    a_in = V4;
    push_exp(a_in);
    iv = 1'b1;
    wait_hs(m);
    a_in = V5;
    run_beats(1);
    for (int i = 0; i < 10; i++) begin
      tick;
      check("bp_out_valid", {31'd0, o_ov}, 1);
      check("bp_in_ready", {31'd0, o_ir}, 0);
    end
    out_ready = 1'b1;
    tick;
    check("bp_release_ov", {31'd0, o_ov}, 0);
    check("bp_release_ready", {31'd0, o_ir}, 1);
    check("bp_not_yet_taken", {31'd0, o_clr}, 0);
    push_exp(V5);
    tick;
    iv = 1'b0;
    run_beats(1);
    tick;
    a_in = V4;
    push_exp(a_in);
    iv = 1'b1;
    wait_hs(m);
    iv = 1'b0;
    k = 0;
    while (!(o_gd && o_t == 8'd7) && k < 40) begin
      tick;
      k++;
    end
    check("reach_t7", o_t, 7);
    rst = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, o_ir}, 0);
    check("abort_busy", {31'd0, o_busy}, 0);
    check("abort_outs", {o_gd, o_a0, o_addr, o_t, o_clr, o_lb, o_ov}, 0);
    q.delete();
    tick;
    tick;
    rst = 1'b1;
    tick;
    check("abort_idle_ready", {31'd0, o_ir}, 1);
    check("abort_idle_busy", {31'd0, o_busy}, 0);
    seen = 0;
    repeat (40) begin
      tick;
      if (o_ov) seen++;
    end
    check("abort_no_out_valid", seen, 0);
    use0 = 1'b1;
    a_in = V4;
    push_exp(a_in);
    iv = 1'b1;
    wait_hs(m);
    a_in = V5;
    run_beats(0);
    push_exp(V5);
    wait_hs(m);
    check("b2b_gap", m, 2);
    iv = 1'b0;
    run_beats(0);
    tick;
    check("b2b_ov_drop", {31'd0, o_ov}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
